// File: rtl/nn_pkg.sv
// Shared types and defaults for the layer-to-layer stream sequencer.
package nn_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    localparam int DATA_W_DEFAULT = 16;

endpackage

// File: rtl/layer_stream_sequencer_if.sv
// Upstream parallel capture bus plus downstream serial element handshake.
interface layer_stream_sequencer_if #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
);
    logic [NN-1:0]           i_valid;
    logic [NN*dataWidth-1:0] i_data;
    logic                    out_ready;
    logic                    x_valid;
    logic [dataWidth-1:0]    x_data;

    modport master (
        output i_valid,
        output i_data,
        output out_ready,
        input  x_valid,
        input  x_data
    );

    modport slave (
        input  i_valid,
        input  i_data,
        input  out_ready,
        output x_valid,
        output x_data
    );
endinterface

// File: rtl/layer_stream_sequencer_buffer.sv
// Capture buffer: parallel write of a whole frame, combinational read at the stream index.
module lss_buffer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16,
    parameter int IDX_W     = $clog2(NN)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [NN*dataWidth-1:0] wdata,
    input  logic [IDX_W:0]          idx,
    output logic [dataWidth-1:0]    rd_data
);
    localparam logic [IDX_W:0] DEPTH = NN[IDX_W:0];

    logic [dataWidth-1:0] mem [NN];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned k = 0; k < NN; k++) begin
                mem[k] <= wdata[k*dataWidth +: dataWidth];
            end
        end
    end

    // idx reaches NN once the last word is on x_data; read value is then unused
    always_comb begin
        rd_data = '0;
        if (idx < DEPTH) begin
            rd_data = mem[idx[IDX_W-1:0]];
        end
    end
endmodule

// File: rtl/layer_stream_sequencer.sv
// Captures a full upstream layer frame in one cycle and streams it element by element downstream.
module layer_stream_sequencer
    import nn_pkg::*;
#(
    parameter int NN        = 30,
    parameter int dataWidth = DATA_W_DEFAULT,
    parameter int IDX_W     = $clog2(NN)
) (
    input  logic                          clk,
    input  logic                          rst,
    layer_stream_sequencer_if.slave       s,
    input  logic                          clr_err,
    output logic                          busy,
    output logic                          layer_done,
    output logic                          overrun,
    output logic                          partial_err,
    output logic [15:0]                   frame_cnt
);
    localparam logic [IDX_W:0] LAST = NN[IDX_W:0];

    state_t               state;
    logic [IDX_W:0]       idx;
    logic [dataWidth-1:0] rd_data;
    logic                 cap_evt;
    logic                 part_evt;
    logic                 handshake;
    logic                 capture;

    assign cap_evt   = &s.i_valid;
    assign part_evt  = (|s.i_valid) && !cap_evt;
    assign handshake = s.x_valid && s.out_ready;
    assign capture   = (state == ST_IDLE) && cap_evt;

    lss_buffer #(
        .NN        (NN),
        .dataWidth (dataWidth),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we      (capture),
        .wdata   (s.i_data),
        .idx     (idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            s.x_valid   <= 1'b0;
            s.x_data    <= '0;
            busy        <= 1'b0;
            layer_done  <= 1'b0;
            overrun     <= 1'b0;
            partial_err <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            layer_done <= 1'b0;

            // clear first so a coincident set condition takes priority
            if (clr_err) begin
                overrun     <= 1'b0;
                partial_err <= 1'b0;
            end
            if (part_evt) begin
                partial_err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cap_evt) begin
                        // element 0 bypasses the buffer, which is written on this same edge
                        s.x_data  <= s.i_data[dataWidth-1:0];
                        s.x_valid <= 1'b1;
                        idx       <= (IDX_W+1)'(1);
                        busy      <= 1'b1;
                        state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (cap_evt) begin
                        overrun <= 1'b1;
                    end
                    if (handshake) begin
                        if (idx == LAST) begin
                            s.x_valid  <= 1'b0;
                            busy       <= 1'b0;
                            idx        <= '0;
                            frame_cnt  <= frame_cnt + 16'd1;
                            layer_done <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            s.x_data <= rd_data;
                            idx      <= idx + (IDX_W+1)'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Scoreboard bench: stimulus queues expected elements/frame counts, a negedge monitor checks them.
module tb_layer_stream_sequencer;
    localparam int NN = 4;
    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_err = 1'b0;
    logic        busy;
    logic        layer_done;
    logic        overrun;
    logic        partial_err;
    logic [15:0] frame_cnt;

    layer_stream_sequencer_if #(.NN(NN), .dataWidth(DW)) bus ();

    layer_stream_sequencer #(.NN(NN), .dataWidth(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .s           (bus),
        .clr_err     (clr_err),
        .busy        (busy),
        .layer_done  (layer_done),
        .overrun     (overrun),
        .partial_err (partial_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] cnt_q[$];
    logic [15:0] model_cnt = '0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          done_due = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // monitor: pops expected elements on each handshake, checks layer_done/frame_cnt a cycle later
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (done_due) begin
                chk("layer_done_pulse", {31'd0, layer_done}, 32'd1);
                if (cnt_q.size() > 0)
                    chk("frame_cnt_at_done", {16'd0, frame_cnt}, {16'd0, cnt_q.pop_front()});
                else
                    fail("frame_cnt_at_done", "no frame expected");
            end else if (layer_done) begin
                fail("layer_done_spurious", "layer_done high with no final transfer");
            end
            done_due = 1'b0;
            if (bus.x_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    fail("xfer_unexpected", $sformatf("got x_data 0x%0h with empty scoreboard", bus.x_data));
                end else begin
                    e = exp_q.pop_front();
                    chk("x_data", {16'd0, bus.x_data}, {16'd0, e.d});
                    done_due = e.last;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input logic [DW-1:0] w2, input logic [DW-1:0] w3, input bit expect_it);
        bus.i_valid = '1;
        bus.i_data  = {w3, w2, w1, w0};
        if (expect_it) begin
            exp_q.push_back('{d: w0, last: 1'b0});
            exp_q.push_back('{d: w1, last: 1'b0});
            exp_q.push_back('{d: w2, last: 1'b0});
            exp_q.push_back('{d: w3, last: 1'b1});
            model_cnt = model_cnt + 16'd1;
            cnt_q.push_back(model_cnt);
        end
        tick();
        bus.i_valid = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.x_valid || busy || exp_q.size() != 0 || done_due) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) fail("wait_idle_timeout", "frame did not complete");
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!layer_done && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) fail("wait_done_timeout", "layer_done never seen");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid   = '0;
        bus.i_data    = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b0;
        repeat (3) tick();

        chk("rst_x_valid", {31'd0, bus.x_valid}, 32'd0);
        chk("rst_x_data", {16'd0, bus.x_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_layer_done", {31'd0, layer_done}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_partial_err", {31'd0, partial_err}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        mon_en = 1'b1;
        rst    = 1'b1;
        tick();

        // partial valid in IDLE
        bus.i_valid = 4'b0101;
        tick();
        bus.i_valid = '0;
        chk("partial_set", {31'd0, partial_err}, 32'd1);
        chk("partial_no_busy", {31'd0, busy}, 32'd0);
        chk("partial_no_valid", {31'd0, bus.x_valid}, 32'd0);
        tick();
        chk("partial_idle_hold", {31'd0, bus.x_valid}, 32'd0);
        clr_err     = 1'b1;
        bus.i_valid = 4'b0101;
        tick();
        clr_err     = 1'b0;
        bus.i_valid = '0;
        chk("partial_set_wins", {31'd0, partial_err}, 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("partial_cleared", {31'd0, partial_err}, 32'd0);

        // reset after two transfers abandons the frame
        frame(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 1'b1);
        tick();
        tick();
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        exp_q.delete();
        cnt_q.delete();
        model_cnt = '0;
        tick();
        chk("midrst_x_valid", {31'd0, bus.x_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("midrst_layer_done", {31'd0, layer_done}, 32'd0);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        frame(16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 1'b1);
        wait_idle(20);
        chk("midrst_refill_cnt", {16'd0, frame_cnt}, 32'd1);

        // basic frame
        frame(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b1);
        wait_idle(20);
        chk("basic_frame_cnt", {16'd0, frame_cnt}, 32'd2);
        chk("basic_busy_low", {31'd0, busy}, 32'd0);

        // backpressure on the 2nd and 3rd x_valid cycles
        frame(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b1);
        tick();
        bus.out_ready = 1'b0;
        chk("bp_x_data_0", {16'd0, bus.x_data}, 32'h0022);
        tick();
        chk("bp_x_data_1", {16'd0, bus.x_data}, 32'h0022);
        chk("bp_x_valid", {31'd0, bus.x_valid}, 32'd1);
        tick();
        chk("bp_x_data_2", {16'd0, bus.x_data}, 32'h0022);
        bus.out_ready = 1'b1;
        wait_idle(20);
        chk("bp_frame_cnt", {16'd0, frame_cnt}, 32'd3);

        // overrun: second full frame while streaming is dropped
        frame(16'h0101, 16'h0202, 16'h0303, 16'h0404, 1'b1);
        frame(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 1'b0);
        wait_idle(20);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        chk("overrun_frame_cnt", {16'd0, frame_cnt}, 32'd4);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("overrun_cleared", {31'd0, overrun}, 32'd0);

        // back-to-back: capture in the layer_done cycle
        frame(16'h1001, 16'h1002, 16'h1003, 16'h1004, 1'b1);
        for (int f = 1; f < 3; f++) begin
            wait_done(20);
            frame(16'(f * 16'h1000 + 16'h1001), 16'(f * 16'h1000 + 16'h1002),
                  16'(f * 16'h1000 + 16'h1003), 16'(f * 16'h1000 + 16'h1004), 1'b1);
        end
        wait_idle(30);
        chk("b2b_frame_cnt", {16'd0, frame_cnt}, 32'd7);
        chk("b2b_no_overrun", {31'd0, overrun}, 32'd0);

        // frame counter wrap
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        model_cnt = 16'hFFFF;
        chk("wrap_preload", {16'd0, frame_cnt}, 32'h0000FFFF);
        frame(16'h2001, 16'h2002, 16'h2003, 16'h2004, 1'b1);
        wait_idle(20);
        chk("wrap_frame_cnt", {16'd0, frame_cnt}, 32'd0);

        tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("cnt_queue_drained", cnt_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
